// File: rtl/ula_pkg.sv
// Shared definitions for the ULA: operation codes, sequencer states and default width.
package ula_pkg;

  localparam int WIDTH_DEFAULT = 8;

  localparam logic OP_SOMA = 1'b0;
  localparam logic OP_SUB  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/celula_soma_sub.sv
// One-bit add/subtract cell: te=1 inverts b so that a carry-in of 1 yields a - b.
module celula_soma_sub (
  input  logic a,
  input  logic b,
  input  logic te,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic b_eff;

  assign b_eff = b ^ te;
  assign s     = a ^ b_eff ^ cin;
  assign cout  = (a & b_eff) | (a & cin) | (b_eff & cin);

endmodule

// File: rtl/sequenciador_somador_serial.sv
// Bit-serial add/subtract sequencer: one result bit per clock, LSB first,
// with a start/done handshake and carry/overflow/zero flags.
module sequenciador_somador_serial
  import ula_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t state, state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             op_r;
  logic             accept;
  logic             last_bit;
  logic             cell_s;
  logic             cell_cout;

  celula_soma_sub u_celula (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .te   (op_r),
    .cin  (carry),
    .s    (cell_s),
    .cout (cell_cout)
  );

  assign r_next   = {cell_s, r_sr[WIDTH-1:1]};
  assign last_bit = (cnt == LAST_BIT);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // DONE accepts a new request directly so start held high gives back-to-back operations.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr      <= '0;
      b_sr      <= '0;
      r_sr      <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      op_r      <= OP_SOMA;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (accept) begin
      a_sr  <= a_in;
      b_sr  <= b_in;
      op_r  <= op;
      carry <= op;
      cnt   <= '0;
    end else if (busy) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      r_sr  <= r_next;
      carry <= cell_cout;
      cnt   <= cnt + CW'(1);
      // carry still holds the carry into the MSB on the final bit
      if (last_bit) begin
        result    <= r_next;
        carry_out <= cell_cout;
        overflow  <= carry ^ cell_cout;
        zero      <= (r_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_sequenciador_somador_serial.sv
// Directed bench for the serial add/subtract sequencer with hand-computed results.
module tb_sequenciador_somador_serial;
  import ula_pkg::*;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  int checks;
  int errors;
  int done_cnt;
  int cycle;

  sequenciador_somador_serial #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Waits on negedges until done is seen; n counts the negedges waited.
  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) check_output({tag, "_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic apply_stimulus(input logic o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a_in  = a;
    b_in  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic o, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_r,
                        input logic exp_c, input logic exp_v, input logic exp_z);
    int n;
    apply_stimulus(o, a, b);
    wait_done(tag, n);
    check_output({tag, "_latency"}, 32'(n), 32'd8);
    check_output({tag, "_result"}, 32'(result), 32'(exp_r));
    check_output({tag, "_flags"}, {29'd0, carry_out, overflow, zero}, {29'd0, exp_c, exp_v, exp_z});
    @(negedge clk);
    check_output({tag, "_done_1cyc"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    int n;
    int t1;
    int t2;
    int dc;
    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    cycle    = 0;
    reset    = 1'b1;
    start    = 1'b0;
    op       = OP_SOMA;
    a_in     = '0;
    b_in     = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_output("reset_outputs", {22'd0, busy, done, result, carry_out, overflow, zero}, 32'd0);

    run_op("add_3c_05", OP_SOMA, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0, 1'b0);
    run_op("sub_05_05", OP_SUB,  8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1);
    run_op("add_ff_01", OP_SOMA, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
    run_op("add_7f_01", OP_SOMA, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
    run_op("sub_80_01", OP_SUB,  8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);

    // Result must hold the previous value while the next operation runs.
    apply_stimulus(OP_SUB, 8'h00, 8'h01);
    repeat (3) @(negedge clk);
    check_output("hold_result", 32'(result), 32'h7F);
    check_output("hold_busy", {30'd0, busy, done}, 32'd2);
    wait_done("sub_00_01", n);
    check_output("sub_00_01_result", 32'(result), 32'hFF);
    check_output("sub_00_01_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
    @(negedge clk);

    // start while busy is ignored
    dc = done_cnt;
    apply_stimulus(OP_SOMA, 8'h11, 8'h22);
    repeat (2) @(negedge clk);
    start = 1'b1;
    a_in  = 8'hAA;
    b_in  = 8'hAA;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore", n);
    check_output("ignore_result", 32'(result), 32'h33);
    repeat (12) @(negedge clk);
    check_output("ignore_one_done", 32'(done_cnt - dc), 32'd1);
    check_output("ignore_idle", {30'd0, busy, done}, 32'd0);

    // Back-to-back with start held high
    @(negedge clk);
    start = 1'b1;
    op    = OP_SOMA;
    a_in  = 8'h01;
    b_in  = 8'h02;
    @(negedge clk);
    wait_done("b2b_1", n);
    t1 = cycle;
    check_output("b2b_1_result", 32'(result), 32'h03);
    a_in = 8'h03;
    b_in = 8'h04;
    @(negedge clk);
    check_output("b2b_reaccept", {30'd0, busy, done}, 32'd2);
    wait_done("b2b_2", n);
    t2 = cycle;
    check_output("b2b_2_result", 32'(result), 32'h07);
    check_output("b2b_spacing", 32'(t2 - t1), 32'd9);
    start = 1'b0;
    @(negedge clk);
    check_output("b2b_idle", {30'd0, busy, done}, 32'd0);

    // Reset in the middle of an operation
    dc = done_cnt;
    apply_stimulus(OP_SOMA, 8'h10, 8'h20);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_output("midrun_reset", {22'd0, busy, done, result, carry_out, overflow, zero}, 32'd0);
    repeat (12) @(negedge clk);
    check_output("midrun_no_done", 32'(done_cnt - dc), 32'd0);
    run_op("add_10_20", OP_SOMA, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sequenciador_somador_serial.md
# sequenciador_somador_serial

Bit-serial add/subtract sequencer for the 8-bit ULA. It computes a full WIDTH-bit two's-complement sum or difference with a single 1-bit add/sub cell, one bit per clock, LSB first. It exchanges operands and results with the control unit through a start/done handshake and reports carry, overflow and zero flags. It is the area-minimal alternative to a ripple of WIDTH cells.

## Interface
- WIDTH, 8: operand and result width in bits (≥2).
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- op  in  1  0 = add (A+B), 1 = subtract (A−B).
- a_in  in  WIDTH  operand A; sampled on the accept edge only.
- b_in  in  WIDTH  operand B; sampled on the accept edge only.
- busy  out  1  high while the bit loop runs.
- done  out  1  one-cycle pulse when result and flags are updated.
- result  out  WIDTH  last completed result.
- carry_out  out  1  final carry; for subtract, 1 = no borrow.
- overflow  out  1  signed overflow of the last operation.
- zero  out  1  result == 0.

## Operation
- States: IDLE, RUN, DONE.
- Accept: in IDLE or DONE with start=1:
  - latch a_in and b_in into shift registers and latch op;
  - set carry register to op (carry-in 1 implements +~B+1);
  - set bit counter to 0 and go to RUN.
- RUN, each edge:
  - the cell computes s = A[0] ^ (B[0]^op) ^ c and the next carry;
  - the A and B shift registers shift right;
  - s enters the MSB of the result shift register;
  - the counter increments.
- On the edge that processes bit WIDTH−1:
  - load result from the shift register including that bit;
  - carry_out = carry out of the MSB;
  - overflow = carry into MSB XOR carry out of MSB;
  - zero = (final result == 0);
  - go to DONE.
- DONE lasts one cycle with done=1. Without start, return to IDLE; with start, accept (back-to-back).
- start while busy=1 is ignored. The operation in flight and the latched operands are unaffected.
- result and flags are updated only at completion and are held stable otherwise, including during a following RUN.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset (any state, including mid-RUN): state IDLE, busy=0, done=0, result=0, carry_out=0, overflow=0, zero=0.
  - Counter, carry and shift registers are cleared.
  - An aborted operation never produces done.
- Accept edge E0. busy=1 from E0 to E_WIDTH. done=1 from E_WIDTH to E_WIDTH+1. Latency is WIDTH edges.
- busy and done are never both 1.
- Throughput: one operation per WIDTH+1 cycles with start held high. A new accept may occur on the edge that ends DONE.
- reset has priority over start on the same edge.

## Structure
- Shared package (ula_pkg):
  - OP_SOMA=1'b0 and OP_SUB=1'b1;
  - state encoding constants IDLE/RUN/DONE;
  - default WIDTH.
- Sub-module celula_soma_sub (combinational):
  - inputs a, b, te, cin; outputs s, cout;
  - b is inverted by te.
  - The sequencer instantiates exactly one.
- Counter width: $clog2(WIDTH).

## Test plan
- add 0x3C+0x05 → result 0x41, carry_out 0, overflow 0, zero 0. done pulses exactly 8 edges after accept, for 1 cycle.
- sub 0x05−0x05 → 0x00, carry_out 1, zero 1, overflow 0. Then add 0xFF+0x01 → 0x00, carry_out 1, zero 1.
- add 0x7F+0x01 → 0x80, overflow 1, carry_out 0. Then sub 0x80−0x01 → 0x7F, overflow 1, carry_out 1.
- sub 0x00−0x01 → 0xFF, carry_out 0, overflow 0. result keeps its previous value until the done edge.
- start with 0x11+0x22, then at RUN cycle 3 pulse start with 0xAA+0xAA → result 0x33, and only one done. Then hold start high with a new operand each time → accepts on the DONE cycle, back-to-back dones 9 cycles apart.
- reset at RUN cycle 4 of 0x10+0x20 → busy 0, all outputs 0, no done. A subsequent add 0x10+0x20 gives 0x30.
